// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle digit-serial adder/subtractor.
// Processes DIGIT bits per clock, LSB first, behind a start/done handshake.
// The result, carry and overflow are registered and held between completions.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - request, sampled only while ready=1
//   sub      - 0: a+b, 1: a-b (sampled with start)
//   a, b     - operands (sampled with start)
//   ready    - a start will be accepted this cycle
//   busy     - digits are being processed
//   done     - one-cycle completion pulse
//   result   - registered sum/difference
//   carry    - carry out of the MSB (for sub: 1 = no borrow)
//   overflow - signed overflow
module serial_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              cin_q, cin_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT:0]    dsum;
    logic              msb_cin;
    logic              accept;
    logic              last_digit;

    // Digit adder on the low DIGIT bits of the operand shift registers.
    assign dsum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, cin_q};

    // Carry into the top bit of the digit, recovered from s = a ^ b ^ cin.
    assign msb_cin = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];

    assign accept     = start && (state_q != ST_BUSY);
    assign last_digit = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cin_d    = cin_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    cin_d   = sub;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                work_d = {dsum[DIGIT-1:0], work_q[WIDTH-1:DIGIT]};
                opa_d  = opa_q >> DIGIT;
                opb_d  = opb_q >> DIGIT;
                cin_d  = dsum[DIGIT];
                cnt_d  = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d  = ST_DONE;
                    result_d = work_d;
                    carry_d  = dsum[DIGIT];
                    ovf_d    = msb_cin ^ dsum[DIGIT];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cin_q    <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready    = (state_q != ST_BUSY);
    assign busy     = (state_q == ST_BUSY);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed-vector bench for serial_addsub with
// hand-computed expected values.
module tb_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic [31:0] er, input logic ec, input logic ev);
        int cyc;
        a = av; b = bv; sub = sv; start = 1'b1;
        tick();
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        wait_done(cyc);
        check({tag, "_lat"},  32'(cyc), 32'd8);
        check({tag, "_res"},  result, er);
        check({tag, "_c"},    {31'd0, carry}, {31'd0, ec});
        check({tag, "_v"},    {31'd0, overflow}, {31'd0, ev});
        tick();
        check({tag, "_done_off"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        check("rst_ready",  {31'd0, ready}, 32'd1);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        tick();

        // 5 + 3 with cycle-by-cycle handshake checks
        a = 32'd5; b = 32'd3; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_busy",  {31'd0, busy}, 32'd1);
            check("t1_ready", {31'd0, ready}, 32'd0);
            check("t1_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        check("t1_done",   {31'd0, done}, 32'd1);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_res",    result, 32'h0000_0008);
        check("t1_c",      {31'd0, carry}, 32'd0);
        check("t1_v",      {31'd0, overflow}, 32'd0);
        tick();
        check("t1_pulse",  {31'd0, done}, 32'd0);
        check("t1_ready2", {31'd0, ready}, 32'd1);

        run_op("maxpos_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("zero_sub1",  32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("minneg_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("wrap_add",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("mix_add",    32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0);
        run_op("eq_sub",     32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_op("neg_sub",    32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("ovf_sub",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

        // start during BUSY is ignored; start during DONE is accepted back-to-back
        a = 32'd5; b = 32'd3; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("b2b_first_lat", 32'(cyc), 32'd5);
        check("b2b_first_res", result, 32'h0000_0008);
        a = 32'd9; b = 32'd9; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("b2b_hold", result, 32'h0000_0008);
            check("b2b_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_res",  result, 32'h0000_0012);
        tick();

        // asynchronous reset mid-operation
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", result, 32'd0);
        check("arst_carry",  {31'd0, carry}, 32'd0);
        check("arst_ovf",    {31'd0, overflow}, 32'd0);
        check("arst_busy",   {31'd0, busy}, 32'd0);
        check("arst_done",   {31'd0, done}, 32'd0);
        check("arst_ready",  {31'd0, ready}, 32'd1);
        tick();
        #2;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done || busy) seen++;
            end
            check("arst_no_done", 32'(seen), 32'd0);
        end
        run_op("post_rst", 32'd2, 32'd2, 1'b0, 32'h0000_0004, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
